// File: rtl/ddr2_arb_pkg.sv
// rtl/ddr2_arb_pkg.sv - shared command codes and arbiter state type
package ddr2_arb_pkg;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WLOCK = 1'b1
   } arb_state_e;

endpackage

// File: rtl/ddr2_tag_fifo.sv
// rtl/ddr2_tag_fifo.sv - channel-id FIFO recording the issuer of each outstanding read
module ddr2_tag_fifo
   import ddr2_arb_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic             do_push;
   logic             do_pop;

   // Occupancy comes from the pointer difference; the extra MSB separates full from empty
   always_comb begin
      count_o = wptr_q - rptr_q;
      full_o  = (count_o == (AW+1)'(DEPTH));
      empty_o = (count_o == '0);
      dout_o  = mem_q[rptr_q[AW-1:0]];
      do_push = push_i && !full_o;
      do_pop  = pop_i && !empty_o;
      wptr_d  = wptr_q + (AW+1)'(do_push);
      rptr_d  = rptr_q + (AW+1)'(do_pop);
   end

   // Pointer registers; contents are don't-care after reset since empty hides them
   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage write
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q[AW-1:0]] <= din_i;
      end
   end

endmodule

// File: rtl/ddr2_request_arbiter.sv
// rtl/ddr2_request_arbiter.sv - N-channel arbiter onto the DDR2 address/write/read FIFOs
module ddr2_request_arbiter
   import ddr2_arb_pkg::*;
#(
   parameter int NUM_CH    = 6,
   parameter int ADDR_W    = 31,
   parameter int DATA_W    = 128,
   parameter int MASK_W    = 16,
   parameter int BEATS     = 2,
   parameter int TAG_DEPTH = 16,
   parameter int RR_MODE   = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             ch_af_wr_en,
   input  logic [3*NUM_CH-1:0]           ch_af_cmd_din,
   input  logic [ADDR_W*NUM_CH-1:0]      ch_addr_din,
   input  logic [NUM_CH-1:0]             ch_wdf_wr_en,
   input  logic [DATA_W*NUM_CH-1:0]      ch_wdf_din,
   input  logic [MASK_W*NUM_CH-1:0]      ch_wdf_mask_din,
   input  logic [NUM_CH-1:0]             ch_rdf_rd_en,
   output logic [NUM_CH-1:0]             ch_af_full,
   output logic [NUM_CH-1:0]             ch_wdf_full,
   output logic [NUM_CH-1:0]             ch_rdf_valid,
   input  logic                          af_full,
   input  logic                          wdf_full,
   input  logic                          rdf_valid,
   output logic                          af_wr_en,
   output logic                          wdf_wr_en,
   output logic                          rdf_rd_en,
   output logic [2:0]                    af_cmd_din,
   output logic [ADDR_W-1:0]             addr_din,
   output logic [DATA_W-1:0]             wdf_din,
   output logic [MASK_W-1:0]             wdf_mask_din,
   output logic [$clog2(TAG_DEPTH):0]    outstanding,
   output logic                          orphan_err
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int BC_W = $clog2(BEATS + 1);

   arb_state_e        state_q, state_d;
   logic [CH_W-1:0]   lock_q, lock_d;
   logic [CH_W-1:0]   rr_q, rr_d;
   logic [BC_W-1:0]   wcnt_q, wcnt_d;
   logic [BC_W-1:0]   rcnt_q, rcnt_d;
   logic              orphan_q, orphan_d;

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] rd_req;
   logic [NUM_CH-1:0] elig;
   logic [NUM_CH-1:0] masked;
   logic [CH_W-1:0]   start_idx;
   logic [CH_W-1:0]   arb_idx;
   logic [CH_W-1:0]   win_idx;
   logic [CH_W-1:0]   tag_head;
   logic [2:0]        win_cmd;
   logic              arb_any;
   logic              grant;
   logic              win_rd;
   logic              ok;
   logic              rd_acc;
   logic              wr_acc;
   logic              rd_beat;
   logic              tag_pop;
   logic              tag_full;
   logic              tag_empty;

   function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
      logic [CH_W-1:0] idx;
      idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (v[i]) idx = CH_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
      return (c == CH_W'(NUM_CH - 1)) ? '0 : c + 1'b1;
   endfunction

   // Request decode and rotate-mask priority search; reads are not eligible while tags are exhausted
   always_comb begin
      start_idx = (RR_MODE != 0) ? rr_q : '0;
      for (int i = 0; i < NUM_CH; i++) begin
         rd_req[i] = ch_af_wr_en[i] && (ch_af_cmd_din[3*i +: 3] == CMD_READ);
         req[i]    = ch_af_wr_en[i] || ch_wdf_wr_en[i];
         elig[i]   = req[i] && !(rd_req[i] && tag_full);
         masked[i] = elig[i] && (CH_W'(i) >= start_idx);
      end
      arb_any = |elig;
      arb_idx = (|masked) ? lowest_set(masked) : lowest_set(elig);
   end

   // Grant, DDR2 strobes and per-channel backpressure; in WLOCK only the locked channel is served
   always_comb begin
      win_idx = '0;
      grant   = 1'b0;
      if (state_q == ST_IDLE) begin
         grant = arb_any;
         if (arb_any) win_idx = arb_idx;
      end else begin
         win_idx = lock_q;
         grant   = req[lock_q];
      end
      win_cmd = ch_af_cmd_din[3*int'(win_idx) +: 3];
      win_rd  = (state_q == ST_IDLE) && ch_af_wr_en[win_idx] && (win_cmd == CMD_READ);
      ok      = !af_full && !wdf_full && !(win_rd && tag_full);

      af_wr_en  = rst && grant && (state_q == ST_IDLE) && ch_af_wr_en[win_idx] && ok;
      wdf_wr_en = rst && grant && ch_wdf_wr_en[win_idx] && ok;

      ch_af_full  = '1;
      ch_wdf_full = '1;
      if (rst && grant) begin
         ch_af_full[win_idx]  = !ok;
         ch_wdf_full[win_idx] = !ok;
      end

      af_cmd_din   = win_cmd;
      addr_din     = ch_addr_din[ADDR_W*int'(win_idx) +: ADDR_W];
      wdf_din      = ch_wdf_din[DATA_W*int'(win_idx) +: DATA_W];
      wdf_mask_din = ch_wdf_mask_din[MASK_W*int'(win_idx) +: MASK_W];

      rd_acc = af_wr_en && (win_cmd == CMD_READ);
      wr_acc = af_wr_en && (win_cmd != CMD_READ);
   end

   // Return path: the oldest tag owns the read FIFO until BEATS beats have been popped
   always_comb begin
      ch_rdf_valid = '0;
      rdf_rd_en    = 1'b0;
      if (rst && !tag_empty) begin
         ch_rdf_valid[tag_head] = rdf_valid;
         rdf_rd_en              = ch_rdf_rd_en[tag_head];
      end
      rd_beat = rdf_valid && rdf_rd_en;
      rcnt_d  = rcnt_q;
      tag_pop = 1'b0;
      if (rd_beat) begin
         if (rcnt_q == BC_W'(BEATS - 1)) begin
            rcnt_d  = '0;
            tag_pop = 1'b1;
         end else begin
            rcnt_d = rcnt_q + 1'b1;
         end
      end
      orphan_d = orphan_q || (rdf_valid && tag_empty);
   end

   // Write-lock FSM and round-robin pointer; the pointer moves only when a transaction completes
   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      wcnt_d  = wcnt_q;
      rr_d    = rr_q;
      case (state_q)
         ST_IDLE: begin
            if (wr_acc) begin
               if (BEATS > 1) begin
                  state_d = ST_WLOCK;
                  lock_d  = win_idx;
                  wcnt_d  = BC_W'(1);
               end else if (RR_MODE != 0) begin
                  rr_d = next_ch(win_idx);
               end
            end
            if (rd_acc && (RR_MODE != 0)) begin
               rr_d = next_ch(win_idx);
            end
         end
         ST_WLOCK: begin
            if (wdf_wr_en) begin
               if (wcnt_q == BC_W'(BEATS - 1)) begin
                  state_d = ST_IDLE;
                  wcnt_d  = '0;
                  if (RR_MODE != 0) rr_d = next_ch(lock_q);
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, counters and sticky error register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         lock_q   <= '0;
         rr_q     <= '0;
         wcnt_q   <= '0;
         rcnt_q   <= '0;
         orphan_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         lock_q   <= lock_d;
         rr_q     <= rr_d;
         wcnt_q   <= wcnt_d;
         rcnt_q   <= rcnt_d;
         orphan_q <= orphan_d;
      end
   end

   assign orphan_err = orphan_q;

   ddr2_tag_fifo #(
      .DEPTH (TAG_DEPTH),
      .WIDTH (CH_W)
   ) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rd_acc),
      .din_i   (win_idx),
      .pop_i   (tag_pop),
      .dout_o  (tag_head),
      .full_o  (tag_full),
      .empty_o (tag_empty),
      .count_o (outstanding)
   );

endmodule

// File: tb/tb_ddr2_request_arbiter.sv
// tb/tb_ddr2_request_arbiter.sv - fixed-priority and round-robin arbiters against a reference model
module tb_ddr2_request_arbiter;

   localparam int NC = 6;
   localparam int AW = 31;
   localparam int DW = 128;
   localparam int MW = 16;
   localparam int NB = 2;
   localparam int TD = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NC-1:0]     ch_af_wr_en, ch_wdf_wr_en, ch_rdf_rd_en;
   logic [3*NC-1:0]   ch_af_cmd_din;
   logic [AW*NC-1:0]  ch_addr_din;
   logic [DW*NC-1:0]  ch_wdf_din;
   logic [MW*NC-1:0]  ch_wdf_mask_din;
   logic              af_full, wdf_full, rdf_valid;

   logic [NC-1:0]     o_caf [2];
   logic [NC-1:0]     o_cwf [2];
   logic [NC-1:0]     o_crv [2];
   logic              o_afw [2];
   logic              o_wdw [2];
   logic              o_rdr [2];
   logic [2:0]        o_cmd [2];
   logic [AW-1:0]     o_addr [2];
   logic [DW-1:0]     o_wd [2];
   logic [MW-1:0]     o_wm [2];
   logic [4:0]        o_out [2];
   logic              o_orph [2];

   int n_checks = 0;
   int n_errors = 0;

   // reference model state, index 0 = fixed priority, 1 = round robin
   int st [2];
   int lk [2];
   int wc [2];
   int rr [2];
   int rc [2];
   int orph [2];
   int tl [2][32];
   int tn [2];

   always #5 clk = ~clk;

   ddr2_request_arbiter #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW),
                          .BEATS(NB), .TAG_DEPTH(TD), .RR_MODE(0)) dut_fp (
      .clk(clk), .rst(rst),
      .ch_af_wr_en(ch_af_wr_en), .ch_af_cmd_din(ch_af_cmd_din), .ch_addr_din(ch_addr_din),
      .ch_wdf_wr_en(ch_wdf_wr_en), .ch_wdf_din(ch_wdf_din), .ch_wdf_mask_din(ch_wdf_mask_din),
      .ch_rdf_rd_en(ch_rdf_rd_en), .ch_af_full(o_caf[0]), .ch_wdf_full(o_cwf[0]),
      .ch_rdf_valid(o_crv[0]), .af_full(af_full), .wdf_full(wdf_full), .rdf_valid(rdf_valid),
      .af_wr_en(o_afw[0]), .wdf_wr_en(o_wdw[0]), .rdf_rd_en(o_rdr[0]), .af_cmd_din(o_cmd[0]),
      .addr_din(o_addr[0]), .wdf_din(o_wd[0]), .wdf_mask_din(o_wm[0]),
      .outstanding(o_out[0]), .orphan_err(o_orph[0]));

   ddr2_request_arbiter #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW),
                          .BEATS(NB), .TAG_DEPTH(TD), .RR_MODE(1)) dut_rr (
      .clk(clk), .rst(rst),
      .ch_af_wr_en(ch_af_wr_en), .ch_af_cmd_din(ch_af_cmd_din), .ch_addr_din(ch_addr_din),
      .ch_wdf_wr_en(ch_wdf_wr_en), .ch_wdf_din(ch_wdf_din), .ch_wdf_mask_din(ch_wdf_mask_din),
      .ch_rdf_rd_en(ch_rdf_rd_en), .ch_af_full(o_caf[1]), .ch_wdf_full(o_cwf[1]),
      .ch_rdf_valid(o_crv[1]), .af_full(af_full), .wdf_full(wdf_full), .rdf_valid(rdf_valid),
      .af_wr_en(o_afw[1]), .wdf_wr_en(o_wdw[1]), .rdf_rd_en(o_rdr[1]), .af_cmd_din(o_cmd[1]),
      .addr_din(o_addr[1]), .wdf_din(o_wd[1]), .wdf_mask_din(o_wm[1]),
      .outstanding(o_out[1]), .orphan_err(o_orph[1]));

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int cmd_of(input int c);
      return int'(ch_af_cmd_din[3*c +: 3]);
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         st[m] = 0; lk[m] = 0; wc[m] = 0; rr[m] = 0; rc[m] = 0; orph[m] = 0; tn[m] = 0;
      end
   endtask

   // Evaluate one cycle of the behavioural model for instance m, compare, then advance it
   task automatic model_step(input int m);
      string pfx;
      int w, c, head;
      bit grant, isrd, ok, tfull, eaf, ewd, erd, pop;
      logic [NC-1:0] ecaf, ecrv;
      pfx = (m == 0) ? "fp." : "rr.";
      tfull = (tn[m] == TD);
      grant = 0;
      w = 0;
      if (st[m] == 0) begin
         for (int k = 0; k < NC; k++) begin
            c = (((m == 1) ? rr[m] : 0) + k) % NC;
            if (!grant && (ch_af_wr_en[c] || ch_wdf_wr_en[c]) &&
                !(ch_af_wr_en[c] && cmd_of(c) == 1 && tfull)) begin
               grant = 1;
               w = c;
            end
         end
      end else begin
         w = lk[m];
         grant = ch_af_wr_en[w] || ch_wdf_wr_en[w];
      end
      isrd = (st[m] == 0) && ch_af_wr_en[w] && (cmd_of(w) == 1);
      ok   = !af_full && !wdf_full && !(isrd && tfull);
      eaf  = rst && grant && (st[m] == 0) && ch_af_wr_en[w] && ok;
      ewd  = rst && grant && ch_wdf_wr_en[w] && ok;
      ecaf = '1;
      if (rst && grant) ecaf[w] = !ok;
      ecrv = '0;
      erd  = 0;
      head = tl[m][0];
      if (rst && tn[m] > 0) begin
         ecrv[head] = rdf_valid;
         erd = ch_rdf_rd_en[head];
      end
      check_val({pfx, "ch_af_full"}, o_caf[m], ecaf);
      check_val({pfx, "ch_wdf_full"}, o_cwf[m], ecaf);
      check_val({pfx, "af_wr_en"}, o_afw[m], eaf);
      check_val({pfx, "wdf_wr_en"}, o_wdw[m], ewd);
      check_val({pfx, "rdf_rd_en"}, o_rdr[m], erd);
      check_val({pfx, "ch_rdf_valid"}, o_crv[m], ecrv);
      check_val({pfx, "outstanding"}, o_out[m], tn[m]);
      check_val({pfx, "orphan_err"}, o_orph[m], orph[m]);
      if (eaf) begin
         check_val({pfx, "af_cmd_din"}, o_cmd[m], ch_af_cmd_din[3*w +: 3]);
         check_val({pfx, "addr_din"}, o_addr[m], ch_addr_din[AW*w +: AW]);
      end
      if (ewd) begin
         check_val({pfx, "wdf_din"}, o_wd[m], ch_wdf_din[DW*w +: DW]);
         check_val({pfx, "wdf_mask_din"}, o_wm[m], ch_wdf_mask_din[MW*w +: MW]);
      end
      if (!rst) begin
         st[m] = 0; lk[m] = 0; wc[m] = 0; rr[m] = 0; rc[m] = 0; orph[m] = 0; tn[m] = 0;
      end else begin
         if (rdf_valid && tn[m] == 0) orph[m] = 1;
         pop = 0;
         if (rdf_valid && erd) begin
            rc[m]++;
            if (rc[m] == NB) begin
               rc[m] = 0;
               pop = 1;
            end
         end
         if (pop) begin
            for (int i = 0; i < 31; i++) tl[m][i] = tl[m][i+1];
            tn[m]--;
         end
         if (eaf && cmd_of(w) == 1) begin
            tl[m][tn[m]] = w;
            tn[m]++;
            if (m == 1) rr[m] = (w + 1) % NC;
         end
         if (st[m] == 0) begin
            if (eaf && cmd_of(w) != 1) begin
               st[m] = 1;
               lk[m] = w;
               wc[m] = 1;
            end
         end else if (ewd) begin
            wc[m]++;
            if (wc[m] == NB) begin
               st[m] = 0;
               wc[m] = 0;
               if (m == 1) rr[m] = (lk[m] + 1) % NC;
            end
         end
      end
   endtask

   // Called at the negative edge: check both models, then move past the next rising edge
   task automatic cyc();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      ch_af_wr_en  = '0;
      ch_wdf_wr_en = '0;
      ch_rdf_rd_en = '0;
      af_full      = 1'b0;
      wdf_full     = 1'b0;
      rdf_valid    = 1'b0;
      rst          = 1'b1;
   endtask

   task automatic rand_data();
      for (int c = 0; c < NC; c++) ch_addr_din[AW*c +: AW] = AW'($urandom);
      for (int i = 0; i < (DW*NC)/32; i++) ch_wdf_din[32*i +: 32] = $urandom;
      for (int i = 0; i < (MW*NC)/32; i++) ch_wdf_mask_din[32*i +: 32] = $urandom;
   endtask

   task automatic set_rd(input int c);
      ch_af_wr_en[c] = 1'b1;
      ch_af_cmd_din[3*c +: 3] = 3'b001;
   endtask

   task automatic set_wr(input int c);
      ch_af_wr_en[c] = 1'b1;
      ch_wdf_wr_en[c] = 1'b1;
      ch_af_cmd_din[3*c +: 3] = 3'b000;
   endtask

   task automatic do_reset();
      clr_in();
      rst = 1'b0;
      @(negedge clk);
      cyc();
      rst = 1'b1;
   endtask

   initial begin
      logic [NC-1:0] e;
      ch_af_cmd_din = '0;
      rand_data();
      clr_in();
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;

      // reset holds everything off even with a request present
      set_rd(0);
      @(negedge clk);
      check_val("reset.ch_af_full", o_caf[0], 6'h3f);
      check_val("reset.af_wr_en", o_afw[1], 1'b0);
      cyc();
      do_reset();

      // ch0 and ch3 read together under fixed priority
      rand_data(); set_rd(0); set_rd(3);
      @(negedge clk);
      check_val("fp.first_grant", o_caf[0], 6'b111110);
      cyc();
      clr_in(); set_rd(3);
      @(negedge clk);
      check_val("fp.second_grant", o_caf[0], 6'b110111);
      cyc();
      clr_in(); rdf_valid = 1'b1; ch_rdf_rd_en = '1;
      @(negedge clk);
      check_val("fp.outstanding_2", o_out[0], 5'd2);
      for (int b = 0; b < 4; b++) begin
         if (b > 0) @(negedge clk);
         e = (b < 2) ? 6'b000001 : 6'b001000;
         check_val("fp.return_route", o_crv[0], e);
         cyc();
      end
      clr_in();
      @(negedge clk);
      check_val("fp.drained", o_out[0], 5'd0);
      cyc();

      // all channels read continuously
      do_reset();
      for (int k = 0; k < 7; k++) begin
         rand_data(); clr_in();
         for (int c = 0; c < NC; c++) set_rd(c);
         @(negedge clk);
         e = 6'h3f & ~(6'd1 << (k % NC));
         check_val("rr.grant_order", o_caf[1], e);
         check_val("fp.grant_fixed", o_caf[0], 6'b111110);
         cyc();
      end

      // ch2 write locks out ch0 until the final beat
      do_reset();
      rand_data(); set_wr(2);
      @(negedge clk);
      check_val("lock.write_grant", o_caf[0], 6'b111011);
      cyc();
      clr_in(); rand_data(); ch_wdf_wr_en[2] = 1'b1; set_rd(0);
      @(negedge clk);
      check_val("lock.ch0_blocked", o_caf[0][0], 1'b1);
      check_val("lock.beat2", o_wdw[0], 1'b1);
      cyc();
      clr_in(); set_rd(0);
      @(negedge clk);
      check_val("lock.ch0_after", o_afw[0], 1'b1);
      cyc();

      // wdf_full stalls the second beat while the lock holds
      do_reset();
      rand_data(); set_wr(1);
      @(negedge clk); cyc();
      clr_in(); ch_wdf_wr_en[1] = 1'b1; wdf_full = 1'b1;
      @(negedge clk);
      check_val("stall.wdf_wr_en", o_wdw[0], 1'b0);
      check_val("stall.ch1_full", o_cwf[0][1], 1'b1);
      cyc();
      set_rd(0);
      @(negedge clk);
      check_val("stall.ch0_blocked", o_caf[1][0], 1'b1);
      cyc();
      wdf_full = 1'b0;
      @(negedge clk);
      check_val("stall.resume", o_wdw[0], 1'b1);
      check_val("stall.ch0_still", o_caf[0][0], 1'b1);
      cyc();
      clr_in(); set_rd(0);
      @(negedge clk);
      check_val("stall.ch0_grant", o_afw[0], 1'b1);
      cyc();

      // tag FIFO exhaustion blocks reads only
      do_reset();
      for (int k = 0; k < TD; k++) begin
         rand_data(); clr_in(); set_rd(4);
         @(negedge clk); cyc();
      end
      clr_in(); rand_data(); set_rd(4); set_wr(5);
      @(negedge clk);
      check_val("tagfull.outstanding", o_out[0], 5'd16);
      check_val("tagfull.read_blocked", o_caf[0][4], 1'b1);
      check_val("tagfull.write_open", o_caf[1][5], 1'b0);
      check_val("tagfull.write_cmd", o_cmd[0], 3'b000);
      cyc();
      clr_in(); ch_wdf_wr_en[5] = 1'b1;
      @(negedge clk); cyc();

      // orphan read data, then reset in the middle of a write lock
      do_reset();
      rdf_valid = 1'b1; ch_rdf_rd_en = '1;
      @(negedge clk);
      check_val("orphan.no_valid", o_crv[0], 6'd0);
      check_val("orphan.no_rd_en", o_rdr[1], 1'b0);
      cyc();
      clr_in();
      @(negedge clk);
      check_val("orphan.sticky", o_orph[0], 1'b1);
      cyc();
      rand_data(); set_wr(3);
      @(negedge clk); cyc();
      clr_in(); ch_wdf_wr_en[3] = 1'b1; set_rd(0); rst = 1'b0;
      @(negedge clk);
      check_val("midreset.ch_af_full", o_caf[0], 6'h3f);
      check_val("midreset.wdf_wr_en", o_wdw[1], 1'b0);
      cyc();
      clr_in(); set_rd(0);
      @(negedge clk);
      check_val("midreset.idle_grant", o_afw[0], 1'b1);
      check_val("midreset.outstanding", o_out[1], 5'd0);
      check_val("midreset.orphan", o_orph[1], 1'b0);
      cyc();

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         rand_data();
         for (int c = 0; c < NC; c++) begin
            ch_af_wr_en[c]  = ($urandom_range(0, 9) < 3);
            ch_wdf_wr_en[c] = ($urandom_range(0, 9) < 3);
            ch_rdf_rd_en[c] = ($urandom_range(0, 9) < 7);
            ch_af_cmd_din[3*c +: 3] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b000;
         end
         af_full   = ($urandom_range(0, 9) == 0);
         wdf_full  = ($urandom_range(0, 9) == 0);
         rdf_valid = ($urandom_range(0, 9) < 3);
         rst       = ($urandom_range(0, 199) != 0);
         @(negedge clk);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
